// File: rtl/wb_pkg.sv
// Shared widths, default depth and the queue entry type for the write-back commit queue.
package wb_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned XLEN             = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_queue_if.sv
// Producer, register-file and forwarding signals of the write-back commit queue.
interface wb_commit_queue_if;
  import wb_pkg::*;

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;
  logic                 alu_ready;
  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_ready;
  logic                 drain_hold;
  logic                 regwrite;
  logic [REG_IDX_W-1:0] write_reg;
  logic [XLEN-1:0]      write_data;
  logic [REG_IDX_W-1:0] fwd_rs1;
  logic [REG_IDX_W-1:0] fwd_rs2;
  logic                 fwd_hit1;
  logic                 fwd_hit2;
  logic [XLEN-1:0]      fwd_data1;
  logic [XLEN-1:0]      fwd_data2;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           drain_hold, fwd_rs1, fwd_rs2,
    input  alu_ready, mem_ready, regwrite, write_reg, write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           drain_hold, fwd_rs1, fwd_rs2,
    output alu_ready, mem_ready, regwrite, write_reg, write_data,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order entry storage with wrapping pointers and occupancy count.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  wb_entry_t [DEPTH-1:0] mem_q;
  logic                  push_ok;
  logic                  pop_ok;

  // Occupancy guards keep the count inside 0..DEPTH whatever the caller does.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: mem/alu arbitration, register-file drive and youngest-match forwarding.
// Forwarding is built only when WB_COMMIT_FWD_EN is defined; otherwise the fwd outputs read 0.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  wb_commit_queue_if.slave   bus,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Mem wins; readiness looks only at full so a same-cycle pop never opens a slot.
  always_comb begin
    bus.mem_ready   = bus.mem_valid & ~full & ~reset;
    bus.alu_ready   = bus.alu_valid & ~full & ~bus.mem_valid & ~reset;
    push            = 1'b0;
    push_entry      = '0;
    if (bus.mem_ready) begin
      push            = (bus.mem_rd != '0);
      push_entry.rd   = bus.mem_rd;
      push_entry.data = bus.mem_data;
    end else if (bus.alu_ready) begin
      push            = (bus.alu_rd != '0);
      push_entry.rd   = bus.alu_rd;
      push_entry.data = bus.alu_data;
    end
  end

  // Head drives the register file directly; stale storage is masked while empty.
  always_comb begin
    pop            = ~empty & ~bus.drain_hold;
    bus.regwrite   = pop;
    bus.write_reg  = empty ? '0 : head.rd;
    bus.write_data = empty ? '0 : head.data;
  end

`ifdef WB_COMMIT_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    idx           = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((bus.fwd_rs1 != '0) && (entries[idx].rd == bus.fwd_rs1)) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = entries[idx].data;
        end
        if ((bus.fwd_rs2 != '0) && (entries[idx].rd == bus.fwd_rs2)) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = entries[idx].data;
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd    = ^{entries, rd_ptr, bus.fwd_rs1, bus.fwd_rs2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue (DEPTH = 4).
module tb_wb_commit_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef WB_COMMIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [2:0] count;
  logic       full;
  logic       empty;
  int         total;
  int         bad;

  wb_commit_queue_if bus ();

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.drain_hold = 1'b0; bus.fwd_rs1 = '0; bus.fwd_rs2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    bus.alu_valid = 1'b1; bus.mem_valid = 1'b1; bus.fwd_rs1 = 5'd1; bus.fwd_rs2 = 5'd2;
    #1;
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%b want=0", bus.regwrite); end
    total++; if (bus.write_reg !== 5'd0) begin bad++; $display("FAIL rst_write_reg got=%0d want=0", bus.write_reg); end
    total++; if (bus.write_data !== 32'h0) begin bad++; $display("FAIL rst_write_data got=%h want=0", bus.write_data); end
    total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL rst_alu_ready got=%b want=0", bus.alu_ready); end
    total++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b want=0", bus.mem_ready); end
    total++; if ({bus.fwd_hit1, bus.fwd_hit2} !== 2'b00) begin bad++; $display("FAIL rst_fwd_hit got=%b want=00", {bus.fwd_hit1, bus.fwd_hit2}); end
    total++; if ({bus.fwd_data1, bus.fwd_data2} !== 64'h0) begin bad++; $display("FAIL rst_fwd_data got=%h want=0", {bus.fwd_data1, bus.fwd_data2}); end
    total++; if ({count, empty, full} !== 5'b000_1_0) begin bad++; $display("FAIL rst_occupancy got=%b want=00010", {count, empty, full}); end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.alu_ready); end
    total++; if (bus.regwrite !== 1'b0) begin bad++; $display("FAIL single_no_early_write got=%b want=0", bus.regwrite); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if ({bus.regwrite, bus.write_reg} !== {1'b1, 5'd5}) begin bad++; $display("FAIL single_write got=%b/%0d want=1/5", bus.regwrite, bus.write_reg); end
    total++; if (bus.write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h want=deadbeef", bus.write_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
    tick();
    total++; if ({empty, bus.regwrite} !== 2'b10) begin bad++; $display("FAIL single_drained got=%b want=10", {empty, bus.regwrite}); end
  endtask

  task automatic test_priority();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
    #1;
    total++; if ({bus.mem_ready, bus.alu_ready} !== 2'b10) begin bad++; $display("FAIL prio_ready got=%b want=10", {bus.mem_ready, bus.alu_ready}); end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL prio_alu_later got=%b want=1", bus.alu_ready); end
    total++; if ({bus.regwrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd3, 32'h11}) begin bad++; $display("FAIL prio_first got=%0d/%h want=3/11", bus.write_reg, bus.write_data); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if ({bus.regwrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd4, 32'h22}) begin bad++; $display("FAIL prio_second got=%0d/%h want=4/22", bus.write_reg, bus.write_data); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL prio_empty got=%b want=1", empty); end
  endtask

  task automatic test_drain_full();
    bus.drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(i); bus.alu_data = 32'h100 + 32'(i);
      #1;
      total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%b want=1", i, bus.alu_ready); end
      tick();
    end
    bus.alu_rd = 5'd5; bus.alu_data = 32'h105;
    #1;
    total++; if ({count, full} !== {3'd4, 1'b1}) begin bad++; $display("FAIL fill_full got=%0d/%b want=4/1", count, full); end
    total++; if ({bus.alu_ready, bus.regwrite} !== 2'b00) begin bad++; $display("FAIL fill_stall got=%b want=00", {bus.alu_ready, bus.regwrite}); end
    tick();
    bus.drain_hold = 1'b0;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL hold_count got=%0d want=4", count); end
    total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL pop_no_ready got=%b want=0", bus.alu_ready); end
    for (int i = 1; i <= 5; i++) begin
      total++; if ({bus.regwrite, bus.write_reg, bus.write_data} !== {1'b1, 5'(i), 32'h100 + 32'(i)}) begin bad++; $display("FAIL drain_%0d got=%b/%0d/%h want=1/%0d", i, bus.regwrite, bus.write_reg, bus.write_data, i); end
      if (i == 2) begin
        total++; if ({bus.alu_ready, count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL fifth_accept got=%b/%0d want=1/3", bus.alu_ready, count); end
      end
      tick();
      if (i == 2) bus.alu_valid = 1'b0;
      #1;
    end
    total++; if ({empty, count} !== {1'b1, 3'd0}) begin bad++; $display("FAIL drain_empty got=%b/%0d want=1/0", empty, count); end
  endtask

  task automatic test_forward();
    bus.drain_hold = 1'b1; bus.fwd_rs1 = 5'd7; bus.fwd_rs2 = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hA;
    #1;
    total++; if ({bus.fwd_hit1, bus.fwd_data1} !== {1'b0, 32'h0}) begin bad++; $display("FAIL fwd_not_in_flight got=%b/%h want=0/0", bus.fwd_hit1, bus.fwd_data1); end
    tick();
    bus.alu_data = 32'hB;
    #1;
    total++; if ({bus.fwd_hit1, bus.fwd_data1} !== {FWD, FWD ? 32'hA : 32'h0}) begin bad++; $display("FAIL fwd_older got=%b/%h want=%b", bus.fwd_hit1, bus.fwd_data1, FWD); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if ({bus.fwd_hit1, bus.fwd_data1} !== {FWD, FWD ? 32'hB : 32'h0}) begin bad++; $display("FAIL fwd_youngest got=%b/%h want=%b", bus.fwd_hit1, bus.fwd_data1, FWD); end
    total++; if ({bus.fwd_hit2, bus.fwd_data2} !== {1'b0, 32'h0}) begin bad++; $display("FAIL fwd_rs_zero got=%b/%h want=0/0", bus.fwd_hit2, bus.fwd_data2); end
    bus.fwd_rs2 = 5'd9;
    #1;
    total++; if ({bus.fwd_hit2, bus.fwd_data2} !== {1'b0, 32'h0}) begin bad++; $display("FAIL fwd_miss got=%b/%h want=0/0", bus.fwd_hit2, bus.fwd_data2); end
    bus.drain_hold = 1'b0;
    #1;
    total++; if ({bus.write_reg, bus.write_data} !== {5'd7, 32'hA}) begin bad++; $display("FAIL fwd_drain_a got=%0d/%h want=7/a", bus.write_reg, bus.write_data); end
    tick();
    total++; if ({bus.fwd_hit1, bus.fwd_data1} !== {FWD, FWD ? 32'hB : 32'h0}) begin bad++; $display("FAIL fwd_after_pop got=%b/%h want=%b", bus.fwd_hit1, bus.fwd_data1, FWD); end
    tick();
    total++; if ({empty, bus.fwd_hit1} !== 2'b10) begin bad++; $display("FAIL fwd_empty got=%b want=10", {empty, bus.fwd_hit1}); end
    bus.fwd_rs1 = '0; bus.fwd_rs2 = '0;
  endtask

  task automatic test_rd_zero();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b want=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if ({count, bus.regwrite, empty} !== {3'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL rd0_dropped got=%0d/%b/%b want=0/0/1", count, bus.regwrite, empty); end
  endtask

  task automatic test_reset_mid();
    bus.drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'hC0 + 32'(i);
      tick();
    end
    bus.alu_valid = 1'b0; bus.drain_hold = 1'b0;
    tick();
    total++; if ({count, bus.write_reg} !== {3'd2, 5'd11}) begin bad++; $display("FAIL mid_state got=%0d/%0d want=2/11", count, bus.write_reg); end
    #2 reset = 1'b1;
    #1;
    total++; if ({bus.regwrite, bus.write_reg, bus.write_data} !== {1'b0, 5'd0, 32'h0}) begin bad++; $display("FAIL mid_rst_drive got=%b/%0d/%h want=0/0/0", bus.regwrite, bus.write_reg, bus.write_data); end
    total++; if ({count, empty, full} !== 5'b000_1_0) begin bad++; $display("FAIL mid_rst_occupancy got=%b want=00010", {count, empty, full}); end
    total++; if ({bus.alu_ready, bus.mem_ready, bus.fwd_hit1, bus.fwd_hit2} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags got=%b want=0000", {bus.alu_ready, bus.mem_ready, bus.fwd_hit1, bus.fwd_hit2}); end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({bus.regwrite, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL post_rst_%0d got=%b/%0d want=0/0", i, bus.regwrite, count); end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_priority();
    test_drain_full();
    test_forward();
    test_rd_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
